// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle instruction sequencer (fetch / decode / exec / mem / writeback).
// Latency: a non-memory instruction takes 4 cycles FETCH..WB. A memory instruction takes 5 cycles.
//          Each cycle spent waiting on imem_ready or dmem_ready adds one cycle.
// Backpressure: holds in FETCH until imem_ready and in MEM until dmem_ready; run is sampled only in IDLE and WB.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   run                 - start / continue execution (sampled in IDLE and WB)
//   imem_req/addr/rdata/ready - instruction fetch handshake (addr = pc)
//   opcode              - instruction-register opcode field to the control unit
//   reg_write_in, mem_read_in, mem_write_in, alu_op_in - decode results from the control unit
//   alu_en, alu_op      - ALU strobe and latched ALU select
//   dmem_req/we/ready   - data-memory handshake
//   rf_we               - register-file write strobe
//   state, busy, instr_count - status: FSM encoding, activity flag, retired-instruction counter
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [3:0]         opcode,
  input  logic               reg_write_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [1:0]         alu_op_in,
  output logic               alu_en,
  output logic [1:0]         alu_op,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               rf_we,
  output logic [2:0]         state,
  output logic               busy,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic [15:0]        instr_count_q, instr_count_d;

  logic [3:0]         ir_opcode;

  assign ir_opcode = ir_q[INSTR_W-1 -: 4];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_op_q      <= 2'b00;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      alu_op_q      <= alu_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    alu_op_d      = alu_op_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // The control unit decodes the opcode driven from ir this cycle.
        reg_write_d = reg_write_in;
        mem_read_d  = mem_read_in;
        mem_write_d = mem_write_in;
        alu_op_d    = alu_op_in;
        state_d     = S_EXEC;
      end

      S_EXEC: begin
        if (ir_opcode == 4'b0000)          state_d = S_HALT;
        else if (mem_read_q || mem_write_q) state_d = S_MEM;
        else                                state_d = S_WB;
      end

      S_MEM: begin
        if (dmem_ready) state_d = S_WB;
      end

      S_WB: begin
        instr_count_d = instr_count_q + 16'd1;
        state_d       = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      // Encoding 7 is unreachable; recover to IDLE if ever entered.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode only from registered state, so no input reaches an output combinationally.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign opcode      = ir_opcode;
  assign alu_en      = (state_q == S_EXEC);
  assign alu_op      = alu_op_q;
  assign dmem_req    = (state_q == S_MEM);
  // Read and write both set resolves to a write.
  assign dmem_we     = (state_q == S_MEM) && mem_write_q;
  assign rf_we       = (state_q == S_WB) && reg_write_q;
  assign state       = state_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [3:0]  opcode;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  alu_op_in;
  logic        alu_en;
  logic [1:0]  alu_op;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic [2:0]  state;
  logic        busy;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  instr_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .opcode       (opcode),
    .reg_write_in (reg_write_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .alu_op_in    (alu_op_in),
    .alu_en       (alu_en),
    .alu_op       (alu_op),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .rf_we        (rf_we),
    .state        (state),
    .busy         (busy),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    run          = 1'b0;
    imem_rdata   = 16'h0000;
    imem_ready   = 1'b0;
    reg_write_in = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    alu_op_in    = 2'b00;
    dmem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || alu_en !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: busy=%b ireq=%b alu_en=%b dreq=%b dwe=%b rfwe=%b want all 0", busy, imem_req, alu_en, dmem_req, dmem_we, rf_we); end
    checks++; if (imem_addr !== 8'h00 || opcode !== 4'h0 || alu_op !== 2'b00 || instr_count !== 16'd0)
      begin errors++; $display("FAIL reset_regs: addr=%h opc=%h alu_op=%b cnt=%0d want 0", imem_addr, opcode, alu_op, instr_count); end
    // Reset must act without a clock edge while a fetch is pending.
    run = 1'b1;
    tick();
    tick();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL reset_fetch_hold: state=%0d ireq=%b want 1/1", state, imem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || imem_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_async: state=%0d ireq=%b busy=%b want 0/0/0", state, imem_req, busy); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    run = 1'b1; imem_rdata = 16'h1234; imem_ready = 1'b1;
    reg_write_in = 1'b1; alu_op_in = 2'b10;
    tick();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1)
      begin errors++; $display("FAIL basic_fetch: state=%0d ireq=%b addr=%h busy=%b want 1/1/00/1", state, imem_req, imem_addr, busy); end
    tick();
    imem_ready = 1'b0;
    checks++; if (state !== 3'd2 || opcode !== 4'h1 || imem_addr !== 8'h01 || imem_req !== 1'b0)
      begin errors++; $display("FAIL basic_decode: state=%0d opc=%h addr=%h ireq=%b want 2/1/01/0", state, opcode, imem_addr, imem_req); end
    tick();
    checks++; if (state !== 3'd3 || alu_en !== 1'b1 || alu_op !== 2'b10 || rf_we !== 1'b0)
      begin errors++; $display("FAIL basic_exec: state=%0d alu_en=%b alu_op=%b rfwe=%b want 3/1/10/0", state, alu_en, alu_op, rf_we); end
    tick();
    run = 1'b0;
    checks++; if (state !== 3'd5 || rf_we !== 1'b1 || alu_en !== 1'b0 || instr_count !== 16'd0)
      begin errors++; $display("FAIL basic_wb: state=%0d rfwe=%b alu_en=%b cnt=%0d want 5/1/0/0", state, rf_we, alu_en, instr_count); end
    tick();
    checks++; if (state !== 3'd0 || instr_count !== 16'd1 || busy !== 1'b0 || rf_we !== 1'b0 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL basic_done: state=%0d cnt=%0d busy=%b rfwe=%b addr=%h want 0/1/0/0/01", state, instr_count, busy, rf_we, imem_addr); end
  endtask

  task automatic test_fetch_wait();
    int n;
    do_reset();
    run = 1'b1; imem_rdata = 16'h1abc; imem_ready = 1'b0; reg_write_in = 1'b1;
    tick();
    run = 1'b0;  // must not abort the instruction already started
    n = 0;
    for (int i = 0; i < 10 && state == 3'd1; i++) begin
      n++;
      if (n == 3) imem_ready = 1'b1;
      tick();
    end
    checks++; if (n !== 3 || state !== 3'd2 || opcode !== 4'h1 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL fetch_wait: fetch_cycles=%0d state=%0d opc=%h addr=%h want 3/2/1/01", n, state, opcode, imem_addr); end
    tick();  // imem_ready still high in EXEC and must be ignored
    checks++; if (state !== 3'd3 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL fetch_ready_ignored: state=%0d addr=%h want 3/01", state, imem_addr); end
    tick();
    tick();
    checks++; if (state !== 3'd0 || instr_count !== 16'd1 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL fetch_wait_done: state=%0d cnt=%0d addr=%h want 0/1/01", state, instr_count, imem_addr); end
  endtask

  task automatic test_mem();
    int n;
    do_reset();
    run = 1'b1; imem_rdata = 16'h2000; imem_ready = 1'b1;
    reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    dmem_ready = 1'b1;  // early dmem_ready outside MEM must be ignored
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXEC
    dmem_ready = 1'b0;
    checks++; if (state !== 3'd3 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mem_exec: state=%0d dreq=%b want 3/0", state, dmem_req); end
    tick();
    checks++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0)
      begin errors++; $display("FAIL mem_load_req: state=%0d dreq=%b dwe=%b want 4/1/0", state, dmem_req, dmem_we); end
    n = 0;
    for (int i = 0; i < 12 && dmem_req == 1'b1; i++) begin
      n++;
      if (n == 4) dmem_ready = 1'b1;
      tick();
    end
    dmem_ready = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL mem_req_cycles: got %0d want 4", n); end
    // Next instruction: read and write both set must resolve to a write.
    imem_rdata = 16'h3000; reg_write_in = 1'b0; mem_read_in = 1'b1; mem_write_in = 1'b1;
    checks++; if (state !== 3'd5 || rf_we !== 1'b1 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL mem_load_wb: state=%0d rfwe=%b addr=%h want 5/1/01", state, rf_we, imem_addr); end
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXEC
    dmem_ready = 1'b1;
    tick();  // MEM
    run = 1'b0;
    checks++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1)
      begin errors++; $display("FAIL mem_rw_write: state=%0d dreq=%b dwe=%b want 4/1/1", state, dmem_req, dmem_we); end
    tick();
    checks++; if (state !== 3'd5 || rf_we !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL mem_rw_wb: state=%0d rfwe=%b dreq=%b want 5/0/0", state, rf_we, dmem_req); end
    tick();
    checks++; if (state !== 3'd0 || instr_count !== 16'd2 || imem_addr !== 8'h02)
      begin errors++; $display("FAIL mem_done: state=%0d cnt=%0d addr=%h want 0/2/02", state, instr_count, imem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    run = 1'b1; imem_rdata = 16'h0000; imem_ready = 1'b1; reg_write_in = 1'b1; mem_write_in = 1'b1;
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXEC
    checks++; if (state !== 3'd3 || alu_en !== 1'b1)
      begin errors++; $display("FAIL halt_exec: state=%0d alu_en=%b want 3/1", state, alu_en); end
    tick();
    checks++; if (state !== 3'd6 || busy !== 1'b0 || rf_we !== 1'b0 || alu_en !== 1'b0 || dmem_req !== 1'b0)
      begin errors++; $display("FAIL halt_enter: state=%0d busy=%b rfwe=%b alu_en=%b dreq=%b want 6/0/0/0/0", state, busy, rf_we, alu_en, dmem_req); end
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      tick();
    end
    checks++; if (state !== 3'd6 || instr_count !== 16'd0 || imem_req !== 1'b0 || imem_addr !== 8'h01)
      begin errors++; $display("FAIL halt_stuck: state=%0d cnt=%0d ireq=%b addr=%h want 6/0/0/01", state, instr_count, imem_req, imem_addr); end
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL halt_reset_exit: state=%0d want 0", state); end
  endtask

  task automatic test_rst_in_mem();
    do_reset();
    run = 1'b1; imem_rdata = 16'h2a00; imem_ready = 1'b1;
    reg_write_in = 1'b1; mem_read_in = 1'b1; alu_op_in = 2'b11;
    repeat (4) tick();
    repeat (2) tick();
    checks++; if (state !== 3'd4 || alu_op !== 2'b11)
      begin errors++; $display("FAIL rstmem_wait: state=%0d alu_op=%b want 4/11", state, alu_op); end
    #2 rst = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || dmem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00 || opcode !== 4'h0 || alu_op !== 2'b00 || instr_count !== 16'd0)
      begin errors++; $display("FAIL rstmem_async: state=%0d dreq=%b busy=%b addr=%h opc=%h alu_op=%b cnt=%0d want all 0", state, dmem_req, busy, imem_addr, opcode, alu_op, instr_count); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0 || state !== 3'd0)
      begin errors++; $display("FAIL rstmem_no_wb: rfwe=%b state=%0d want 0/0", rf_we, state); end
    rst = 1'b0; dmem_ready = 1'b0; run = 1'b1; imem_ready = 1'b0;
    tick();
    checks++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 8'h00)
      begin errors++; $display("FAIL rstmem_refetch: state=%0d ireq=%b addr=%h want 1/1/00", state, imem_req, imem_addr); end
    do_reset();
  endtask

  task automatic test_run_drop();
    do_reset();
    run = 1'b1; imem_rdata = 16'h1000; imem_ready = 1'b1; reg_write_in = 1'b1;
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXEC
    run = 1'b0;
    tick();
    checks++; if (state !== 3'd5 || rf_we !== 1'b1)
      begin errors++; $display("FAIL rundrop_wb: state=%0d rfwe=%b want 5/1", state, rf_we); end
    tick();
    checks++; if (state !== 3'd0 || busy !== 1'b0 || instr_count !== 16'd1)
      begin errors++; $display("FAIL rundrop_idle: state=%0d busy=%b cnt=%0d want 0/0/1", state, busy, instr_count); end
    tick();
    checks++; if (state !== 3'd0 || imem_req !== 1'b0)
      begin errors++; $display("FAIL rundrop_stay: state=%0d ireq=%b want 0/0", state, imem_req); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run = 1'b1; imem_rdata = 16'h1000; imem_ready = 1'b1;
    for (int i = 0; i < 2000 && instr_count != 16'd255; i++) tick();
    checks++; if (instr_count !== 16'd255 || state !== 3'd1 || imem_addr !== 8'hFF)
      begin errors++; $display("FAIL wrap_at_ff: cnt=%0d state=%0d addr=%h want 255/1/ff", instr_count, state, imem_addr); end
    repeat (4) tick();
    checks++; if (instr_count !== 16'd256 || state !== 3'd1 || imem_addr !== 8'h00)
      begin errors++; $display("FAIL wrap_to_00: cnt=%0d state=%0d addr=%h want 256/1/00", instr_count, state, imem_addr); end
    run = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    imem_rdata = 16'h0000;
    imem_ready = 1'b0;
    reg_write_in = 1'b0;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    alu_op_in = 2'b00;
    dmem_ready = 1'b0;
    test_reset();
    test_basic();
    test_fetch_wait();
    test_mem();
    test_halt();
    test_rst_in_mem();
    test_run_drop();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
